// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores over a req/ack
// handshake, with fault reporting and programmable wait states.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req          access request, sampled only while idle
//   we           1 = store, 0 = load
//   addr         byte address
//   width        0 = byte, 1 = half, 3 = word, 2 = illegal
//   sign         load extension: 0 = zero, 1 = sign
//   wdata        right-aligned store data
//   rdata        extended load result, held until the next response
//   ack          one-cycle response strobe
//   err          access faulted (valid with ack, held)
//   err_code     0 none, 1 misaligned, 2 illegal width, 3 out of range
//   busy         request in flight
module dmem_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE        = 32'h10010000,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  width,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] WS_M1 =
        4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    state;
    logic [3:0]    cnt;

    logic          we_q;
    logic [1:0]    width_q;
    logic          sign_q;
    logic [31:0]   wdata_q;
    logic [IW+1:0] off_q;

    logic [31:0]   mem [DEPTH];

    // Fault classification on the request as presented; the result is
    // latched at capture so it is equivalent to checking captured fields.
    logic [31:0] off;
    logic [1:0]  code_in;

    assign off = addr - BASE;

    always_comb begin
        code_in = 2'd0;
        if (width == 2'd2)
            code_in = 2'd2;
        else if ((addr[1:0] & width) != 2'b00)
            code_in = 2'd1;
        // addresses below BASE wrap to a huge offset and land here too
        else if (|off[31:IW+2])
            code_in = 2'd3;
    end

    logic          capture;
    logic [IW-1:0] idx;
    logic [1:0]    bo;
    logic [3:0]    mask;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic [31:0]   shifted;
    logic [31:0]   ld_val;

    assign capture   = (state == S_IDLE) && req;
    assign idx       = off_q[IW+1:2];
    assign bo        = off_q[1:0];
    assign lane_en   = mask << bo;
    assign lane_data = wdata_q << {bo, 3'b000};
    assign shifted   = mem[idx] >> {bo, 3'b000};

    always_comb begin
        mask   = 4'hF;
        ld_val = shifted;
        unique case (1'b1)
            width_q == 2'd0: begin
                mask   = 4'h1;
                ld_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            end
            width_q == 2'd1: begin
                mask   = 4'h3;
                ld_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                mask   = 4'hF;
                ld_val = shifted;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            we_q    <= we;
            width_q <= width;
            sign_q  <= sign;
            wdata_q <= wdata;
            off_q   <= off[IW+1:0];
        end
    end

    // A store whose access edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && state == S_ACC && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i])
                    mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            rdata    <= 32'd0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        if (code_in != 2'd0) begin
                            err      <= 1'b1;
                            err_code <= code_in;
                            rdata    <= 32'd0;
                            state    <= S_RESP;
                        end else if (WAIT_STATES > 0) begin
                            cnt   <= WS_M1;
                            state <= S_WAIT;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0)
                        state <= S_ACC;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_ACC: begin
                    err      <= 1'b0;
                    err_code <= 2'd0;
                    rdata    <= we_q ? 32'd0 : ld_val;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack  = (state == S_RESP);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance without wait states, one with three.
// Expected responses are queued at drive time and popped on each ack.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE = 32'h10010000;
    localparam int D0 = 1024;
    localparam int D3 = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic        we = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [1:0]  width = 2'd0;

    logic [31:0] rdata0, rdata3;
    logic        ack0, ack3, err0, err3, busy0, busy3;
    logic [1:0]  code0, code3;

    dmem_ctrl #(.DEPTH(D0), .BASE(BASE), .WAIT_STATES(0)) u_d0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr),
        .width(width), .sign(sign), .wdata(wdata), .rdata(rdata0),
        .ack(ack0), .err(err0), .err_code(code0), .busy(busy0)
    );

    dmem_ctrl #(.DEPTH(D3), .BASE(BASE), .WAIT_STATES(3)) u_d3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr),
        .width(width), .sign(sign), .wdata(wdata), .rdata(rdata3),
        .ack(ack3), .err(err3), .err_code(code3), .busy(busy3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } resp_t;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [1:0]  wd;
        logic        s;
        logic [31:0] d;
        logic [31:0] ex;
        logic        err;
        logic [1:0]  code;
    } op_t;

    resp_t exp0_q[$], obs0_q[$], exp3_q[$], obs3_q[$];
    int    at0_q[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;

    logic [7:0] mb [int unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack0) begin
            obs0_q.push_back({rdata0, err0, code0});
            at0_q.push_back(cyc);
        end
        if (ack3)
            obs3_q.push_back({rdata3, err3, code3});
    end

    function automatic int nbytes(input logic [1:0] wd);
        return (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a,
                                           input logic [1:0] wd,
                                           input logic s);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < nbytes(wd); i++)
            if (mb.exists(a + i)) v[8*i +: 8] = mb[a + i];
        if (s && wd == 2'd0 && v[7])  v[31:8]  = '1;
        if (s && wd == 2'd1 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] wd,
                           input logic [31:0] d);
        for (int i = 0; i < nbytes(wd); i++)
            mb[a + i] = d[8*i +: 8];
    endtask

    task automatic set_in(input logic w, input logic [31:0] a,
                          input logic [1:0] wd, input logic s,
                          input logic [31:0] d);
        we = w; addr = a; width = wd; sign = s; wdata = d;
    endtask

    task automatic go0(input logic w, input logic [31:0] a,
                       input logic [1:0] wd, input logic s,
                       input logic [31:0] d);
        set_in(w, a, wd, s, d);
        req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
    endtask

    task automatic go3(input logic w, input logic [31:0] a,
                       input logic [1:0] wd, input logic s,
                       input logic [31:0] d);
        set_in(w, a, wd, s, d);
        req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
    endtask

    // lat counts negedges from the capture edge to the ack sample
    task automatic wait0(output int lat);
        lat = 0;
        while (obs0_q.size() == 0 && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait3(output int lat);
        lat = 0;
        while (obs3_q.size() == 0 && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack0, err0, code0, busy0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags0: got ack=%b err=%b code=%0d busy=%b, need 0",
                     ack0, err0, code0, busy0);
        end
        checks++;
        if (rdata0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata0: got %h, need 0", rdata0);
        end
        checks++;
        if ({ack3, err3, code3, busy3, rdata3} !== 37'b0) begin
            errors++;
            $display("FAIL reset_d3: got ack=%b err=%b code=%0d busy=%b rdata=%h, need 0",
                     ack3, err3, code3, busy3, rdata3);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy0 !== 1'b0 || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b ack=%b, need 0 0", busy0, ack0);
        end
    endtask

    task automatic test_extend();
        op_t         ops[$];
        op_t         op;
        resp_t       o, e;
        int          lat;
        logic [31:0] bx [8];
        bx = '{32'hFFFFFFEF, 32'hFFFFFFBE, 32'hFFFFFFAD, 32'hFFFFFFDE,
               32'h000000EF, 32'h000000BE, 32'h000000AD, 32'h000000DE};
        ops.push_back({1'b1, BASE, 2'd3, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2'd0});
        for (int i = 0; i < 8; i++)
            ops.push_back({1'b0, BASE + 32'(i % 4), 2'd0, 1'(i < 4), 32'h0,
                           bx[i], 1'b0, 2'd0});
        ops.push_back({1'b1, BASE, 2'd3, 1'b0, 32'h11223344, 32'h0, 1'b0, 2'd0});
        ops.push_back({1'b1, BASE + 32'd2, 2'd1, 1'b0, 32'h00008001, 32'h0, 1'b0, 2'd0});
        ops.push_back({1'b0, BASE, 2'd3, 1'b0, 32'h0, 32'h80013344, 1'b0, 2'd0});
        ops.push_back({1'b0, BASE + 32'd2, 2'd1, 1'b1, 32'h0, 32'hFFFF8001, 1'b0, 2'd0});
        ops.push_back({1'b0, BASE + 32'd2, 2'd1, 1'b0, 32'h0, 32'h00008001, 1'b0, 2'd0});
        ops.push_back({1'b0, BASE, 2'd1, 1'b1, 32'h0, 32'h00003344, 1'b0, 2'd0});
        foreach (ops[i]) begin
            op = ops[i];
            exp0_q.push_back({op.ex, op.err, op.code});
            go0(op.w, op.a, op.wd, op.s, op.d);
            wait0(lat);
            e = exp0_q.pop_front();
            checks++;
            if (obs0_q.size() == 0) begin
                errors++;
                $display("FAIL extend[%0d]: no ack, need rdata=%h", i, e.rdata);
            end else begin
                o = obs0_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL extend[%0d]: got rdata=%h err=%b code=%0d, need rdata=%h err=%b code=%0d",
                             i, o.rdata, o.err, o.code, e.rdata, e.err, e.code);
                end
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL extend_lat[%0d]: got %0d, need 2", i, lat);
            end
        end
    endtask

    task automatic test_faults();
        op_t         ops[$];
        op_t         op;
        resp_t       o, e;
        int          lat;
        logic [31:0] top;
        top = BASE + 32'(4 * (D0 - 1));
        ops.push_back({1'b1, top, 2'd3, 1'b0, 32'h0BADF00D, 32'h0, 1'b0, 2'd0});
        ops.push_back({1'b1, BASE, 2'd2, 1'b0, 32'h55555555, 32'h0, 1'b1, 2'd2});
        ops.push_back({1'b1, BASE + 32'd1, 2'd2, 1'b0, 32'h55555555, 32'h0, 1'b1, 2'd2});
        ops.push_back({1'b1, BASE + 32'd2, 2'd3, 1'b0, 32'h55555555, 32'h0, 1'b1, 2'd1});
        ops.push_back({1'b1, BASE + 32'd1, 2'd1, 1'b0, 32'h55555555, 32'h0, 1'b1, 2'd1});
        ops.push_back({1'b1, BASE + 32'(4 * D0), 2'd3, 1'b0, 32'h55555555, 32'h0, 1'b1, 2'd3});
        ops.push_back({1'b1, BASE - 32'd4, 2'd3, 1'b0, 32'h55555555, 32'h0, 1'b1, 2'd3});
        ops.push_back({1'b0, BASE - 32'd3, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 2'd1});
        ops.push_back({1'b0, BASE + 32'd1, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 2'd1});
        ops.push_back({1'b0, BASE, 2'd3, 1'b0, 32'h0, 32'h80013344, 1'b0, 2'd0});
        ops.push_back({1'b0, top, 2'd3, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 2'd0});
        foreach (ops[i]) begin
            op = ops[i];
            exp0_q.push_back({op.ex, op.err, op.code});
            go0(op.w, op.a, op.wd, op.s, op.d);
            wait0(lat);
            e = exp0_q.pop_front();
            checks++;
            if (obs0_q.size() == 0) begin
                errors++;
                $display("FAIL fault[%0d]: no ack, need code=%0d", i, e.code);
            end else begin
                o = obs0_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL fault[%0d]: got rdata=%h err=%b code=%0d, need rdata=%h err=%b code=%0d",
                             i, o.rdata, o.err, o.code, e.rdata, e.err, e.code);
                end
            end
            checks++;
            if (lat !== (op.err ? 1 : 2)) begin
                errors++;
                $display("FAIL fault_lat[%0d]: got %0d, need %0d",
                         i, lat, op.err ? 1 : 2);
            end
        end
    endtask

    task automatic test_wait_states();
        resp_t o, e;
        int    lat;
        logic  bz;
        exp3_q.push_back({32'h0, 1'b0, 2'd0});
        go3(1'b1, BASE, 2'd3, 1'b0, 32'h01020304);
        wait3(lat);
        e = exp3_q.pop_front();
        checks++;
        if (obs3_q.size() == 0 || lat !== 5) begin
            errors++;
            $display("FAIL ws_store: got lat=%0d acks=%0d, need lat=5 acks=1",
                     lat, obs3_q.size());
        end
        if (obs3_q.size() != 0) o = obs3_q.pop_front();

        exp3_q.push_back({32'h01020304, 1'b0, 2'd0});
        set_in(1'b0, BASE, 2'd3, 1'b0, 32'h0);
        req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        lat = 0;
        bz = 1'b1;
        while (obs3_q.size() == 0 && lat < 20) begin
            if (busy3 !== 1'b1) bz = 1'b0;
            req3 = (lat == 1);
            @(negedge clk); #1; lat++;
        end
        req3 = 1'b0;
        if (busy3 !== 1'b1) bz = 1'b0;
        @(posedge clk); #1;
        e = exp3_q.pop_front();
        checks++;
        if (obs3_q.size() == 0) begin
            errors++;
            $display("FAIL ws_load: no ack, need rdata=%h", e.rdata);
        end else begin
            o = obs3_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL ws_load: got rdata=%h err=%b, need rdata=%h err=%b",
                         o.rdata, o.err, e.rdata, e.err);
            end
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL ws_lat: got %0d, need 5", lat);
        end
        checks++;
        if (bz !== 1'b1) begin
            errors++;
            $display("FAIL ws_busy: got busy dropout, need busy high throughout");
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (obs3_q.size() != 0) begin
            errors++;
            $display("FAIL ws_single_ack: got %0d extra acks, need 0", obs3_q.size());
            obs3_q.delete();
        end

        exp3_q.push_back({32'h0, 1'b1, 2'd2});
        go3(1'b0, BASE, 2'd2, 1'b0, 32'h0);
        wait3(lat);
        e = exp3_q.pop_front();
        checks++;
        if (obs3_q.size() == 0 || lat !== 1) begin
            errors++;
            $display("FAIL ws_fault: got lat=%0d acks=%0d, need lat=1 acks=1",
                     lat, obs3_q.size());
        end else begin
            o = obs3_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ws_fault_resp: got err=%b code=%0d, need err=1 code=2",
                         o.err, o.code);
            end
        end
    endtask

    task automatic test_reset_mid();
        resp_t       o, e;
        int          lat;
        logic [31:0] ra [2];
        logic [31:0] rv [2];
        ra = '{BASE + 32'd8, BASE + 32'd12};
        rv = '{32'h11111111, 32'h22222222};
        for (int i = 0; i < 2; i++) begin
            exp3_q.push_back({32'h0, 1'b0, 2'd0});
            go3(1'b1, ra[i], 2'd3, 1'b0, rv[i]);
            wait3(lat);
            e = exp3_q.pop_front();
            if (obs3_q.size() != 0) o = obs3_q.pop_front();
        end

        go3(1'b1, BASE + 32'd8, 2'd0, 1'b0, 32'h000000A5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy3 !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_busy: got %b, need 0", busy3);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (obs3_q.size() != 0) begin
            errors++;
            $display("FAIL rst_wait_ack: got %0d acks, need 0", obs3_q.size());
            obs3_q.delete();
        end

        go3(1'b1, BASE + 32'd12, 2'd0, 1'b0, 32'h000000A5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (obs3_q.size() != 0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL rst_acc: got acks=%0d busy=%b, need 0 0",
                     obs3_q.size(), busy3);
            obs3_q.delete();
        end

        for (int i = 0; i < 2; i++) begin
            exp3_q.push_back({rv[i], 1'b0, 2'd0});
            go3(1'b0, ra[i], 2'd3, 1'b0, 32'h0);
            wait3(lat);
            e = exp3_q.pop_front();
            checks++;
            if (obs3_q.size() == 0) begin
                errors++;
                $display("FAIL rst_readback[%0d]: no ack, need %h", i, e.rdata);
            end else begin
                o = obs3_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL rst_readback[%0d]: got %h, need %h",
                             i, o.rdata, e.rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        resp_t       o, e;
        logic [31:0] a, d, ex;
        logic [1:0]  wd;
        logic        s, w;
        int          n;
        logic [1:0]  lwd [5];
        logic        lsg [5];
        int          lof [5];
        lwd = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
        lsg = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        lof = '{3, 2, 0, 1, 0};
        obs0_q.delete();
        at0_q.delete();
        req0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                w  = 1'b1;
                a  = BASE + 32'h40 + 32'(4 * k);
                wd = 2'd3;
                s  = 1'b0;
                d  = 32'h8001F00F ^ (32'(k) * 32'h01357911);
                ex = 32'h0;
                m_store(a, wd, d);
            end else begin
                w  = 1'b0;
                a  = BASE + 32'h40 + 32'(4 * (k - 5) + lof[k-5]);
                wd = lwd[k-5];
                s  = lsg[k-5];
                d  = 32'h0;
                ex = m_load(a, wd, s);
            end
            set_in(w, a, wd, s, d);
            exp0_q.push_back({ex, 1'b0, 2'd0});
            if (k == 0)
                @(posedge clk);
            else
                repeat (3) @(posedge clk);
            #1;
        end
        req0 = 1'b0;
        n = 0;
        while (obs0_q.size() < 10 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (obs0_q.size() != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d acks, need 10", obs0_q.size());
        end
        for (int k = 0; k < 10; k++) begin
            e = exp0_q.pop_front();
            if (obs0_q.size() == 0) break;
            o = obs0_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: got rdata=%h err=%b, need rdata=%h err=%b",
                         k, o.rdata, o.err, e.rdata, e.err);
            end
            if (k > 0) begin
                checks++;
                if (at0_q[k] - at0_q[k-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: got %0d cycles, need 3",
                             k, at0_q[k] - at0_q[k-1]);
                end
            end
        end
        exp0_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_extend();
        test_faults();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
